demux_1to2_4bit_tdm: RTL and testbench
======================================

Name: demux_1to2_4bit_tdm

Overview:
- Receive-side counterpart of the 2-to-1 4-bit mux.
- A single WIDTH-bit word stream carries time-interleaved channel-a and channel-b words; a sync flag marks each channel-a word.
- The block tracks frame phase with an FSM, steers each word into registered a/b outputs with valid pulses, and flags framing errors and stalled frames.
- It sits directly after a link fed by the mux path and recovers two independent channels.

Parameters:
- WIDTH, 4, data word width for in, a and b.
- TIMEOUT, 15, maximum idle cycles allowed in EXP_B before the frame is abandoned; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in  input  WIDTH  multiplexed data word
- in_valid  input  1  in/sync qualify this cycle
- sync  input  1  1 = word is channel a (frame start), 0 = channel b
- a  output  WIDTH  last captured channel-a word
- b  output  WIDTH  last captured channel-b word
- a_valid  output  1  1-cycle pulse, a updated
- b_valid  output  1  1-cycle pulse, b updated
- pair_valid  output  1  1-cycle pulse, a/b hold a matched frame
- locked  output  1  1 when FSM is not in HUNT
- err  output  1  1-cycle pulse on framing error or timeout

Behaviour:
- Reset: rst sampled at posedge clk.
  - a=0, b=0, all pulse outputs 0, locked=0.
  - FSM enters HUNT; idle counter is cleared.
  - rst overrides every other input in the same cycle.
  - Reset mid-frame discards the partial frame with no err.
- Registered outputs: a/b/valids/err update on the clock edge after the qualifying in_valid cycle (latency 1). Pulses last exactly 1 cycle. a/b hold their values between updates.
- in_valid=0 cycles do not change state. The only exception is the idle counter in EXP_B.
- FSM states: HUNT, EXP_B, EXP_A.
- HUNT:
  - in_valid and sync: a<=in, a_valid=1, go to EXP_B.
  - in_valid and not sync: word dropped, stay in HUNT, no err.
- EXP_B:
  - in_valid and not sync: b<=in, b_valid=1, pair_valid=1, go to EXP_A.
  - in_valid and sync: premature frame start. Set err=1, a<=in, a_valid=1, stay in EXP_B (resynchronise to the new frame).
  - no in_valid: idle counter increments. When the counter reaches TIMEOUT, set err=1, go to HUNT, clear the counter. a keeps its value.
  - Idle counter clears on any in_valid and on every entry to EXP_B. Counter width is 8 bits.
- EXP_A:
  - in_valid and sync: a<=in, a_valid=1, go to EXP_B.
  - in_valid and not sync: missing frame start. Set err=1, word dropped, go to HUNT.
- locked = (state != HUNT), registered with the state.
- If a timeout and an in_valid land in the same cycle, the in_valid wins: it is processed normally and no timeout is raised.
- sync and in are don't-care when in_valid=0.

Optional Feature:
- Macro: DEMUX_ERR_CNT_EN.
- When defined, adds output err_cnt, 8 bits wide.
  - Increments on every err pulse and saturates at 255.
  - Cleared only by rst.
  - Updates in the same cycle as err.
- When undefined, there is no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset then lock: rst for 2 cycles, then words (in=2,sync=1),(in=9,sync=0) on consecutive cycles.
  - Expected: a=2 with a_valid one cycle after the first word; b=9 with b_valid and pair_valid one cycle after the second word.
  - Expected: locked=1 from the first capture; err stays 0.
- Streaming frames: send a/b pairs 3/A, 4/B, 5/C back-to-back.
  - Expected: three pair_valid pulses with matching a/b; locked held at 1; err=0.
- Hunt drop: after reset send (in=7,sync=0).
  - Expected: no valid pulses, locked=0, err=0.
  - Then send (6,sync=1),(D,sync=0). Expected: pair a=6, b=D.
- Framing errors:
  - In EXP_B, send (8,sync=1). Expected: err pulse, a=8, a_valid pulse, still locked.
  - In EXP_A, send (F,sync=0). Expected: err pulse, b unchanged, locked=0 next cycle.
- Timeout: capture a=4, then hold in_valid=0 for 15 cycles.
  - Expected: err pulse on the 15th idle edge, locked=0, no b_valid.
  - Repeat with in=C,sync=0 on the 15th idle cycle. Expected: b=C is captured and there is no err.
- Reset mid-frame: capture a=5, then assert rst.
  - Expected: a=0, locked=0, no err.
- With DEMUX_ERR_CNT_EN defined:
  - Expected: err_cnt counts 1, 2, ... over the scenarios above.
  - After 300 forced errors, expected err_cnt=255.

Source files
------------

// File: rtl/demux_1to2_4bit_tdm.sv
// demux_1to2_4bit_tdm: recovers channels a/b from a sync-flagged TDM word stream.
// Define DEMUX_ERR_CNT_EN to add a saturating 8-bit err_cnt output.
module demux_1to2_4bit_tdm #(
    parameter int WIDTH = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             a_valid,
    output logic             b_valid,
    output logic             pair_valid,
    output logic             locked,
    output logic             err
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
    typedef enum logic [1:0] {HUNT, EXP_B, EXP_A} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [7:0]       idle, idle_n;
    logic [WIDTH-1:0] a_n, b_n;
    logic             a_valid_n, b_valid_n, pair_valid_n, err_n;

    always_comb begin
        state_n      = state;
        idle_n       = idle;
        a_n          = a;
        b_n          = b;
        a_valid_n    = 1'b0;
        b_valid_n    = 1'b0;
        pair_valid_n = 1'b0;
        err_n        = 1'b0;
        case (state)
            HUNT: if (in_valid && sync) begin
                a_n       = in;
                a_valid_n = 1'b1;
                state_n   = EXP_B;
                idle_n    = '0;
            end
            EXP_B: if (in_valid) begin
                idle_n = '0;
                if (sync) begin
                    // premature frame start: resynchronise on the new a word
                    err_n     = 1'b1;
                    a_n       = in;
                    a_valid_n = 1'b1;
                end else begin
                    b_n          = in;
                    b_valid_n    = 1'b1;
                    pair_valid_n = 1'b1;
                    state_n      = EXP_A;
                end
            end else if (idle == IDLE_LAST) begin
                err_n   = 1'b1;
                state_n = HUNT;
                idle_n  = '0;
            end else begin
                idle_n = idle + 8'd1;
            end
            EXP_A: if (in_valid) begin
                if (sync) begin
                    a_n       = in;
                    a_valid_n = 1'b1;
                    state_n   = EXP_B;
                    idle_n    = '0;
                end else begin
                    err_n   = 1'b1;
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            idle       <= '0;
            a          <= '0;
            b          <= '0;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            idle       <= idle_n;
            a          <= a_n;
            b          <= b_n;
            a_valid    <= a_valid_n;
            b_valid    <= b_valid_n;
            pair_valid <= pair_valid_n;
            err        <= err_n;
            locked     <= state_n != HUNT;
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (err_n && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_demux_1to2_4bit_tdm.sv
// tb_demux_1to2_4bit_tdm: directed and random checks of the TDM demux against a queued reference model.
module tb_demux_1to2_4bit_tdm;
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       av;
        logic       bv;
        logic       pv;
        logic       lk;
        logic       er;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in = '0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] a, b;
    logic       a_valid, b_valid, pair_valid, locked, err;
    logic [7:0] err_cnt_obs;

    int errors = 0;
    int checks = 0;

    obs_t       q[$];
    logic [7:0] qc[$];
    int         m_state = 0;
    int         m_cnt = 0;
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    int         m_ec = 0;

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
    assign err_cnt_obs = err_cnt;
`else
    assign err_cnt_obs = '0;
`endif

    demux_1to2_4bit_tdm #(.WIDTH(4), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .in_valid(in_valid),
        .sync(sync),
        .a(a),
        .b(b),
        .a_valid(a_valid),
        .b_valid(b_valid),
        .pair_valid(pair_valid),
        .locked(locked),
        .err(err)
`ifdef DEMUX_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic s, input logic [3:0] d);
        obs_t e, o;
        logic [7:0] ec;
        @(negedge clk);
        rst = r; in_valid = v; sync = s; in = d;
        e = '0;
        if (r) begin
            m_state = 0; m_cnt = 0; m_a = '0; m_b = '0; m_ec = 0;
        end else if (v) begin
            m_cnt = 0;
            if (m_state == 0) begin
                if (s) begin m_a = d; e.av = 1; m_state = 1; end
            end else if (m_state == 1) begin
                if (s) begin m_a = d; e.av = 1; e.er = 1; end
                else begin m_b = d; e.bv = 1; e.pv = 1; m_state = 2; end
            end else begin
                if (s) begin m_a = d; e.av = 1; m_state = 1; end
                else begin e.er = 1; m_state = 0; end
            end
        end else if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == 15) begin e.er = 1; m_state = 0; m_cnt = 0; end
        end
        if (e.er && m_ec < 255) m_ec++;
        e.a = m_a; e.b = m_b; e.lk = (m_state != 0);
        q.push_back(e);
        qc.push_back(8'(m_ec));
        @(posedge clk);
        #1;
        o = '{a: a, b: b, av: a_valid, bv: b_valid, pv: pair_valid, lk: locked, er: err};
        e = q.pop_front();
        ec = qc.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL outputs observed=%h expected=%h (a,b,av,bv,pv,lk,er)", o, e);
        end
`ifdef DEMUX_ERR_CNT_EN
        chk("err_cnt", err_cnt_obs, ec);
`endif
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reset_a", {4'h0, a}, 8'h00);
        chk("reset_locked", {7'h0, locked}, 8'h00);
        cyc(0, 1, 1, 4'h2);
        chk("lock_a", {4'h0, a}, 8'h02);
        chk("lock_locked", {7'h0, locked}, 8'h01);
        cyc(0, 1, 0, 4'h9);
        chk("lock_b", {4'h0, b}, 8'h09);
        chk("lock_pair", {7'h0, pair_valid}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 4'(3 + i));
            cyc(0, 1, 0, 4'(4'hA + i));
            chk("stream_pair", {a, b}, {4'(3 + i), 4'(4'hA + i)});
            chk("stream_err", {7'h0, err}, 8'h00);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 4'h7);
        chk("hunt_drop", {a_valid, b_valid, locked, err}, 8'h00);
        cyc(0, 1, 1, 4'h6);
        cyc(0, 1, 0, 4'hD);
        chk("hunt_pair", {a, b}, 8'h6D);
        cyc(0, 1, 1, 4'h1);
        cyc(0, 1, 1, 4'h8);
        chk("early_sync", {a, 1'b0, err, a_valid, locked}, 8'h87);
        cyc(0, 1, 0, 4'h3);
        cyc(0, 1, 0, 4'hF);
        chk("missing_sync", {b, 2'b0, err, locked}, 8'h32);
        cyc(0, 1, 1, 4'h4);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0);
        chk("pre_timeout", {6'h0, err, locked}, 8'h01);
        cyc(0, 0, 0, 0);
        chk("timeout", {a, 1'b0, err, b_valid, locked}, 8'h44);
        cyc(0, 1, 1, 4'h4);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 4'hC);
        chk("timeout_race", {b, 1'b0, err, b_valid, locked}, 8'hC3);
        cyc(0, 1, 1, 4'h5);
        chk("mid_a", {4'h0, a}, 8'h05);
        cyc(1, 1, 1, 4'h9);
        chk("mid_reset", {a, 2'b0, err, locked}, 8'h00);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
`ifdef DEMUX_ERR_CNT_EN
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 4'h1);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 4'(i));
        chk("err_cnt_sat", err_cnt_obs, 8'hFF);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
